// File: rtl/hot_buffer_loader.sv
// Fill stage for the HotBuffer. Each load command is split into rows, each row is
// assembled from narrow memory beats, and every complete row is written with one strobe.
module hot_buffer_loader #(
    parameter int DATA_W     = 32,
    parameter int ROW_WORDS  = 256,
    parameter int BEAT_WORDS = 8,
    parameter int IDX_W      = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [IDX_W-1:0]              cmd_base_idx,
    input  logic [IDX_W:0]                cmd_rows,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [BEAT_WORDS*DATA_W-1:0]  mem_data,
    output logic                          hb_write_en,
    output logic [IDX_W-1:0]              hb_idx,
    output logic [ROW_WORDS*DATA_W-1:0]   hb_data,
    output logic                          busy,
    output logic                          done
);

    localparam int BEATS     = ROW_WORDS / BEAT_WORDS;
    localparam int BEAT_BITS = BEAT_WORDS * DATA_W;
    localparam int BCNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
    localparam logic [IDX_W:0]    MAX_ROWS  = (IDX_W+1)'(1 << IDX_W);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t              state, state_next;
    logic [IDX_W-1:0]    base;
    logic [IDX_W:0]      rows;
    logic [IDX_W:0]      row_cnt;
    logic [BCNT_W-1:0]   beat_cnt;
    logic                cmd_fire;
    logic                beat_fire;
    logic                last_row;

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign beat_fire = mem_valid & mem_ready;
    assign last_row  = (row_cnt + (IDX_W+1)'(1)) == rows;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Handshakes are decoded from raw inputs here so the ready outputs never feed back.
    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        mem_ready   = 1'b0;
        hb_write_en = 1'b0;
        hb_idx      = '0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = rst;
                if (cmd_valid && rst)
                    state_next = (cmd_rows == '0) ? DONE : FILL;
            end
            FILL: begin
                mem_ready = 1'b1;
                busy      = 1'b1;
                if (mem_valid && beat_cnt == LAST_BEAT)
                    state_next = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                hb_write_en = 1'b1;
                hb_idx      = base + row_cnt[IDX_W-1:0];
                state_next  = last_row ? DONE : FILL;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base     <= '0;
            rows     <= '0;
            row_cnt  <= '0;
            beat_cnt <= '0;
            hb_data  <= '0;
        end else begin
            if (cmd_fire) begin
                base     <= cmd_base_idx;
                rows     <= (cmd_rows > MAX_ROWS) ? MAX_ROWS : cmd_rows;
                row_cnt  <= '0;
                beat_cnt <= '0;
            end
            if (beat_fire) begin
                hb_data[beat_cnt*BEAT_BITS +: BEAT_BITS] <= mem_data;
                beat_cnt <= beat_cnt + BCNT_W'(1);
            end
            if (hb_write_en) begin
                beat_cnt <= '0;
                row_cnt  <= row_cnt + (IDX_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_hot_buffer_loader.sv
// Randomized bench for hot_buffer_loader: expected rows come from a flat word array
// indexed by global word number and a queue of expected (row index, row number) writes.
module tb_hot_buffer_loader;

    localparam int DATA_W     = 32;
    localparam int ROW_WORDS  = 256;
    localparam int BEAT_WORDS = 8;
    localparam int IDX_W      = 6;
    localparam int BEATS      = ROW_WORDS / BEAT_WORDS;
    localparam int NROWS      = 1 << IDX_W;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [IDX_W-1:0]             cmd_base_idx;
    logic [IDX_W:0]               cmd_rows;
    logic                         mem_valid;
    logic                         mem_ready;
    logic [BEAT_WORDS*DATA_W-1:0] mem_data;
    logic                         hb_write_en;
    logic [IDX_W-1:0]             hb_idx;
    logic [ROW_WORDS*DATA_W-1:0]  hb_data;
    logic                         busy;
    logic                         done;

    hot_buffer_loader #(
        .DATA_W(DATA_W), .ROW_WORDS(ROW_WORDS), .BEAT_WORDS(BEAT_WORDS), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base_idx(cmd_base_idx), .cmd_rows(cmd_rows),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
        .hb_write_en(hb_write_en), .hb_idx(hb_idx), .hb_data(hb_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int row;
    } exp_t;

    int unsigned words[$];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          write_cnt = 0;
    int          done_cnt = 0;
    int          beats_seen = 0;
    bit          expect_done = 1'b0;
    bit          prev_acc = 1'b0;
    logic [ROW_WORDS*DATA_W-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Per-cycle observer: protocol invariants plus row comparison against the model.
    always @(negedge clk) begin
        exp_t e;
        int   nbad;
        if (!rst) begin
            check("reset_outputs", 64'({cmd_ready, mem_ready, hb_write_en, hb_idx, busy, done}), 64'(0));
            check("reset_hb_data", 64'(|hb_data), 64'(0));
            beats_seen  = 0;
            expect_done = 1'b0;
            prev_acc    = 1'b0;
        end else begin
            check("cmd_ready_vs_busy", 64'(cmd_ready), 64'(!busy));
            if (!prev_acc)
                check("hb_data_stable", 64'(hb_data == prev_data), 64'(1));
            if (expect_done) begin
                check("done_after_last_write", 64'(done), 64'(1));
                expect_done = 1'b0;
            end
            if (done) done_cnt++;
            if (hb_write_en) begin
                write_cnt++;
                check("mem_ready_in_write", 64'(mem_ready), 64'(0));
                check("beats_before_write", 64'(beats_seen), 64'(BEATS));
                beats_seen = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(hb_write_en), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("hb_idx", 64'(hb_idx), 64'(e.idx));
                    nbad = 0;
                    for (int i = 0; i < ROW_WORDS; i++)
                        if (hb_data[i*DATA_W +: DATA_W] !== words[e.row*ROW_WORDS + i]) nbad++;
                    check("hb_data_bad_words", 64'(nbad), 64'(0));
                    check("hb_data_last_word", 64'(hb_data[(ROW_WORDS-1)*DATA_W +: DATA_W]),
                          64'(words[e.row*ROW_WORDS + ROW_WORDS - 1]));
                    if (exp_q.size() == 0) expect_done = 1'b1;
                end
            end else begin
                check("hb_idx_nonwrite", 64'(hb_idx), 64'(0));
            end
            prev_acc = mem_valid && mem_ready;
            if (prev_acc) beats_seen++;
        end
        prev_data = hb_data;
    end

    task automatic prep(input int base, input int rows, input int mode);
        int nr;
        exp_t e;
        nr = (rows > NROWS) ? NROWS : rows;
        if (mode != 2) begin
            words.delete();
            for (int g = 0; g < nr*ROW_WORDS; g++)
                words.push_back((mode == 0) ? unsigned'(g) : $urandom());
        end
        for (int r = 0; r < nr; r++) begin
            e.idx = (base + r) % NROWS;
            e.row = r;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_cmd(input int base, input int rows);
        int guard;
        guard        = 0;
        cmd_valid    = 1'b1;
        cmd_base_idx = IDX_W'(base);
        cmd_rows     = (IDX_W+1)'(rows);
        @(negedge clk);
        while (!cmd_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_accept_in_time", 64'(cmd_ready), 64'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic feed_beats(input int nbeats, input int duty);
        int b;
        int guard;
        b = 0;
        guard = 0;
        while (b < nbeats && guard < 20000) begin
            mem_valid = ($urandom_range(99) < duty);
            for (int k = 0; k < BEAT_WORDS; k++)
                mem_data[k*DATA_W +: DATA_W] = words[b*BEAT_WORDS + k];
            @(negedge clk);
            if (mem_valid && mem_ready) b++;
            @(posedge clk); #1;
            guard++;
        end
        mem_valid = 1'b0;
        check("feed_complete", 64'(b), 64'(nbeats));
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!done && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", 64'(done), 64'(1));
        @(posedge clk); #1;
    endtask

    task automatic run_cmd(input int base, input int rows, input int mode, input int duty);
        int nr;
        int w0;
        int d0;
        nr = (rows > NROWS) ? NROWS : rows;
        w0 = write_cnt;
        d0 = done_cnt;
        prep(base, rows, mode);
        send_cmd(base, rows);
        feed_beats(nr*BEATS, duty);
        wait_done();
        @(negedge clk);
        check("write_count", 64'(write_cnt - w0), 64'(nr));
        check("done_count", 64'(done_cnt - d0), 64'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        int w0;
        int guard;
        rst          = 1'b0;
        cmd_valid    = 1'b0;
        cmd_base_idx = '0;
        cmd_rows     = '0;
        mem_valid    = 1'b0;
        mem_data     = '0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;

        // single row, word value equals its global index
        run_cmd(5, 1, 0, 100);
        // index wrap 62,63,0,1
        run_cmd(62, 4, 1, 100);
        // same data at full rate and at roughly half rate
        run_cmd(17, 2, 1, 100);
        run_cmd(17, 2, 2, 50);

        // zero-row command: done on the cycle after accept, nothing else
        w0 = write_cnt;
        send_cmd(9, 0);
        @(negedge clk);
        check("zero_rows_done", 64'(done), 64'(1));
        check("zero_rows_mem_ready", 64'(mem_ready), 64'(0));
        check("zero_rows_write", 64'(hb_write_en), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("zero_rows_idle", 64'(busy), 64'(0));
        check("zero_rows_writes", 64'(write_cnt - w0), 64'(0));
        @(posedge clk); #1;

        // abort after 10 beats of row 0
        w0 = write_cnt;
        prep(3, 2, 1);
        send_cmd(3, 2);
        feed_beats(10, 100);
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_write", 64'(write_cnt - w0), 64'(0));
        check("abort_idle", 64'(cmd_ready), 64'(1));
        @(posedge clk); #1;
        run_cmd(0, 1, 1, 100);

        // second command held while busy, accepted right after done
        prep(10, 1, 1);
        send_cmd(10, 1);
        cmd_valid    = 1'b1;
        cmd_base_idx = IDX_W'(20);
        cmd_rows     = (IDX_W+1)'(1);
        feed_beats(BEATS, 100);
        guard = 0;
        @(negedge clk);
        while (!done && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("held_cmd_first_done", 64'(done), 64'(1));
        @(negedge clk);
        check("held_cmd_ready_after_done", 64'(cmd_ready), 64'(1));
        prep(20, 1, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("held_cmd_accepted", 64'(busy), 64'(1));
        @(posedge clk); #1;
        feed_beats(BEATS, 70);
        wait_done();

        // random commands
        for (int n = 0; n < 6; n++)
            run_cmd($urandom_range(NROWS-1), $urandom_range(3), 1, $urandom_range(100, 30));

        // row count above capacity saturates to 64 rows
        run_cmd($urandom_range(NROWS-1), 100, 1, 100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
